// File: rtl/parking_pkg.sv
// Shared types and constants for the parking-lot hourly log writer.
package parking_pkg;

  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned NUM_HOURS = 8;
  localparam int unsigned CAPACITY  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    ADVANCE = 2'd2,
    DONE    = 2'd3
  } logger_state_t;

endpackage

// File: rtl/rush_tracker.sv
// Tracks whether the lot has hit capacity today and emits rush start/end/none pulses.
module rush_tracker
  import parking_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] snap,
  input  logic             eval,
  input  logic             day_end,
  output logic             start_rush,
  output logic             end_rush,
  output logic             no_rush
);

  logic rush_seen, rush_over;
  logic rush_seen_nx, rush_over_nx;
  logic start_nx, end_nx, no_nx;
  logic full;

  // Counts above capacity still count as full; at most one pulse per evaluation.
  always_comb begin
    rush_seen_nx = rush_seen;
    rush_over_nx = rush_over;
    start_nx     = 1'b0;
    end_nx       = 1'b0;
    no_nx        = 1'b0;
    full         = (snap >= CNT_W'(CAPACITY));
    if (eval) begin
      if (!rush_seen && full) begin
        start_nx     = 1'b1;
        rush_seen_nx = 1'b1;
      end else if (rush_seen && !rush_over && !full) begin
        end_nx       = 1'b1;
        rush_over_nx = 1'b1;
      end
    end else if (day_end) begin
      if (!rush_seen) begin
        no_nx = 1'b1;
      end else if (!rush_over) begin
        end_nx       = 1'b1;
        rush_over_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rush_seen  <= 1'b0;
      rush_over  <= 1'b0;
      start_rush <= 1'b0;
      end_rush   <= 1'b0;
      no_rush    <= 1'b0;
    end else begin
      rush_seen  <= rush_seen_nx;
      rush_over  <= rush_over_nx;
      start_rush <= start_nx;
      end_rush   <= end_nx;
      no_rush    <= no_nx;
    end
  end

endmodule

// File: rtl/hourly_count_logger.sv
// Writes one car-count snapshot per hour tick into the log RAM and owns the workday hour.
module hourly_count_logger
  import parking_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              hour_inc,
  input  logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] wrdata,
  output logic              wren,
  output logic [CNT_W-1:0]  hour,
  output logic              start_rush,
  output logic              end_rush,
  output logic              no_rush,
  output logic              day_done,
  output logic              tick_ovf
);

  logger_state_t     state, state_nx;
  logic [CNT_W-1:0]  snap, snap_nx;
  logic [CNT_W-1:0]  pend_data, pend_data_nx;
  logic              pend_valid, pend_valid_nx;
  logic              tick_ovf_nx;
  logic [CNT_W-1:0]  hour_nx;
  logic [ADDR_W-1:0] wraddress_nx;
  logic [DATA_W-1:0] wrdata_nx;
  logic              wren_nx, day_done_nx;
  logic              eval_c, day_end_c;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pend_valid || hour_inc) state_nx = WRITE;
      WRITE:   state_nx = ADVANCE;
      ADVANCE: state_nx = (hour == CNT_W'(NUM_HOURS - 1)) ? DONE : IDLE;
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Tick capture, pending buffer and next values of the registered outputs.
  always_comb begin
    snap_nx       = snap;
    pend_data_nx  = pend_data;
    pend_valid_nx = pend_valid;
    tick_ovf_nx   = tick_ovf;
    hour_nx       = hour;
    case (state)
      IDLE: begin
        if (pend_valid) begin
          snap_nx       = pend_data;
          pend_valid_nx = hour_inc;
          if (hour_inc) pend_data_nx = count;
        end else if (hour_inc) begin
          snap_nx = count;
        end
      end
      WRITE, ADVANCE: begin
        if (hour_inc) begin
          if (pend_valid) begin
            tick_ovf_nx = 1'b1;
          end else begin
            pend_valid_nx = 1'b1;
            pend_data_nx  = count;
          end
        end
        if (state == ADVANCE) begin
          if (hour < CNT_W'(NUM_HOURS)) hour_nx = hour + CNT_W'(1);
          // A tick still queued when the day closes can never be logged.
          if (state_nx == DONE && pend_valid_nx) begin
            pend_valid_nx = 1'b0;
            tick_ovf_nx   = 1'b1;
          end
        end
      end
      default: if (hour_inc) tick_ovf_nx = 1'b1;
    endcase

    wren_nx      = (state_nx == WRITE);
    wraddress_nx = wren_nx ? ADDR_W'(hour) : '0;
    wrdata_nx    = wren_nx ? DATA_W'(snap_nx) : '0;
    day_done_nx  = (state_nx == DONE);
    eval_c       = (state == WRITE);
    day_end_c    = (state == ADVANCE) && (state_nx == DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      snap       <= '0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      tick_ovf   <= 1'b0;
      hour       <= '0;
      wren       <= 1'b0;
      wraddress  <= '0;
      wrdata     <= '0;
      day_done   <= 1'b0;
    end else begin
      snap       <= snap_nx;
      pend_data  <= pend_data_nx;
      pend_valid <= pend_valid_nx;
      tick_ovf   <= tick_ovf_nx;
      hour       <= hour_nx;
      wren       <= wren_nx;
      wraddress  <= wraddress_nx;
      wrdata     <= wrdata_nx;
      day_done   <= day_done_nx;
    end
  end

  rush_tracker u_rush_tracker (
    .clock      (clock),
    .reset_n    (reset_n),
    .snap       (snap),
    .eval       (eval_c),
    .day_end    (day_end_c),
    .start_rush (start_rush),
    .end_rush   (end_rush),
    .no_rush    (no_rush)
  );

endmodule

// File: tb/tb_hourly_count_logger.sv
// Directed bench for hourly_count_logger: RAM writes, hour counter, rush pulses, tick overflow.
module tb_hourly_count_logger;

  logic        clock;
  logic        reset_n;
  logic        hour_inc;
  logic [3:0]  count;
  logic [3:0]  wraddress;
  logic [15:0] wrdata;
  logic        wren;
  logic [3:0]  hour;
  logic        start_rush, end_rush, no_rush, day_done, tick_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] ram_m [16];
  int          wr_count, start_cnt, end_cnt, no_cnt;
  int          start_hour, end_hour, no_hour;
  int          wr_addr_q [$];

  logic [3:0] cur  [8];
  logic [3:0] day3 [8] = '{4'd0, 4'd1, 4'd3, 4'd3, 4'd2, 4'd0, 4'd0, 4'd1};
  logic [3:0] day4 [8] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd1, 4'd0, 4'd2, 4'd1};
  logic [3:0] day5 [8] = '{4'd0, 4'd1, 4'd0, 4'd2, 4'd1, 4'd3, 4'd9, 4'd3};

  hourly_count_logger dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .hour_inc   (hour_inc),
    .count      (count),
    .wraddress  (wraddress),
    .wrdata     (wrdata),
    .wren       (wren),
    .hour       (hour),
    .start_rush (start_rush),
    .end_rush   (end_rush),
    .no_rush    (no_rush),
    .day_done   (day_done),
    .tick_ovf   (tick_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model and pulse recorder, sampled mid-cycle.
  always @(negedge clock) begin
    if (reset_n) begin
      if (wren) begin
        ram_m[wraddress] = wrdata;
        wr_count++;
        wr_addr_q.push_back(int'(wraddress));
      end
      if (start_rush) begin start_cnt++; start_hour = int'(hour); end
      if (end_rush)   begin end_cnt++;   end_hour   = int'(hour); end
      if (no_rush)    begin no_cnt++;    no_hour    = int'(hour); end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 16; i++) ram_m[i] = 16'hFFFF;
    wr_count = 0; start_cnt = 0; end_cnt = 0; no_cnt = 0;
    start_hour = -1; end_hour = -1; no_hour = -1;
    wr_addr_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n  = 1'b0;
    hour_inc = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    clear_mon();
  endtask

  // One tick, then wait through WRITE and ADVANCE so the next tick lands in IDLE.
  task automatic tick(input logic [3:0] c);
    @(negedge clock);
    hour_inc = 1'b1;
    count    = c;
    @(negedge clock);
    hour_inc = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  task automatic run_day();
    for (int h = 0; h < 8; h++) tick(cur[h]);
    repeat (3) @(negedge clock);
  endtask

  task automatic check_ram();
    for (int i = 0; i < 8; i++) check($sformatf("ram%0d", i), 32'(ram_m[i]), 32'(cur[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    hour_inc = 1'b0;
    count    = 4'd0;
    clear_mon();
    #12;
    check("rst_wren", 32'(wren), 32'd0);
    check("rst_hour", 32'(hour), 32'd0);
    check("rst_flags", 32'({start_rush, end_rush, no_rush, day_done, tick_ovf}), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Single tick latency: write in the cycle after the tick, hour bumps two cycles later.
    @(negedge clock);
    hour_inc = 1'b1;
    count    = 4'd2;
    @(posedge clock); #1;
    hour_inc = 1'b0;
    check("t2_wren", 32'(wren), 32'd1);
    check("t2_addr", 32'(wraddress), 32'd0);
    check("t2_data", 32'(wrdata), 32'h0002);
    check("t2_hour0", 32'(hour), 32'd0);
    @(posedge clock); #1;
    check("t2_wren_low", 32'(wren), 32'd0);
    check("t2_hour_adv", 32'(hour), 32'd0);
    @(posedge clock); #1;
    check("t2_hour1", 32'(hour), 32'd1);

    // Asynchronous reset in the middle of a WRITE.
    @(negedge clock);
    hour_inc = 1'b1;
    count    = 4'd5;
    @(posedge clock); #1;
    hour_inc = 1'b0;
    check("t1_pre_wren", 32'(wren), 32'd1);
    check("t1_pre_addr", 32'(wraddress), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("t1_wren", 32'(wren), 32'd0);
    check("t1_bus", 32'({wraddress, wrdata}), 32'd0);
    check("t1_hour", 32'(hour), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    clear_mon();

    // Rush day: start at hour 2, end at hour 4.
    cur = day3;
    run_day();
    check_ram();
    check("t3_writes", 32'(wr_count), 32'd8);
    check("t3_start_n", 32'(start_cnt), 32'd1);
    check("t3_start_h", 32'(start_hour), 32'd2);
    check("t3_end_n", 32'(end_cnt), 32'd1);
    check("t3_end_h", 32'(end_hour), 32'd4);
    check("t3_no_rush", 32'(no_cnt), 32'd0);
    check("t3_done", 32'(day_done), 32'd1);
    check("t3_hour", 32'(hour), 32'd8);
    check("t3_ovf", 32'(tick_ovf), 32'd0);

    // Quiet day: only no_rush at hour 8.
    do_reset();
    cur = day4;
    run_day();
    check_ram();
    check("t4_no_n", 32'(no_cnt), 32'd1);
    check("t4_no_h", 32'(no_hour), 32'd8);
    check("t4_start_n", 32'(start_cnt), 32'd0);
    check("t4_end_n", 32'(end_cnt), 32'd0);
    check("t4_done", 32'(day_done), 32'd1);

    // Rush that never clears: end_rush fires on DONE entry with hour 8.
    do_reset();
    cur = day5;
    run_day();
    check_ram();
    check("t5_start_n", 32'(start_cnt), 32'd1);
    check("t5_start_h", 32'(start_hour), 32'd5);
    check("t5_end_n", 32'(end_cnt), 32'd1);
    check("t5_end_h", 32'(end_hour), 32'd8);
    check("t5_no_rush", 32'(no_cnt), 32'd0);

    // Three back-to-back ticks: one captured, one pending, one dropped.
    do_reset();
    @(negedge clock);
    hour_inc = 1'b1;
    count    = 4'd5;
    @(negedge clock);
    count    = 4'd6;
    @(negedge clock);
    count    = 4'd7;
    @(negedge clock);
    hour_inc = 1'b0;
    repeat (6) @(negedge clock);
    check("t6_writes", 32'(wr_count), 32'd2);
    check("t6_addr0", 32'(wr_addr_q[0]), 32'd0);
    check("t6_addr1", 32'(wr_addr_q[1]), 32'd1);
    check("t6_ram0", 32'(ram_m[0]), 32'd5);
    check("t6_ram1", 32'(ram_m[1]), 32'd6);
    check("t6_ovf", 32'(tick_ovf), 32'd1);
    for (int h = 2; h < 8; h++) tick(4'(h));
    repeat (3) @(negedge clock);
    check("t6_writes8", 32'(wr_count), 32'd8);
    check("t6_done", 32'(day_done), 32'd1);
    tick(4'd1);
    repeat (2) @(negedge clock);
    check("t6_post_writes", 32'(wr_count), 32'd8);
    check("t6_post_wren", 32'(wren), 32'd0);
    check("t6_post_ovf", 32'(tick_ovf), 32'd1);
    check("t6_post_hour", 32'(hour), 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
